mac_seq_ctrl: RTL and testbench

//   Sequencer for the MAC datapath: accepts a start command and a vector length,

---
 rtl/mac_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl
//   Sequencer for the MAC register datapath. A start command captures the
//   vector length, the controller clears the accumulator, then pulls operand
//   pairs over a valid/ready stream and strobes the operand, accumulator and
//   result registers. The finished result is offered with a valid/ready
//   handshake. All state changes on the falling edge of clk_n.
//
// Ports
//   clk_n      in   clock, state updates on its falling edge
//   rst_n      in   synchronous active-low reset
//   start      in   start command, honoured only when idle
//   len        in   number of operand pairs, captured with start
//   abort      in   cancel the current operation
//   in_valid   in   operand pair present at the datapath inputs
//   in_ready   out  controller will accept an operand pair
//   ld_op      out  load strobe for operand A/B registers
//   ld_acc     out  load strobe for the accumulator
//   acc_clr    out  accumulator input mux selects zero
//   ld_out     out  load strobe for the result register
//   out_valid  out  result register holds the finished result
//   out_ready  in   consumer takes the result
//   busy       out  controller is not idle
//   cnt        out  operand pairs accumulated so far
// ---------------------------------------------------------------------------
module mac_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk_n,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld_op,
  output logic             ld_acc,
  output logic             acc_clr,
  output logic             ld_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FETCH  = 3'd2,
    S_ACC    = 3'd3,
    S_OUTPUT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] len_q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             in_ready_r;
  logic             ld_acc_r;
  logic             acc_clr_r;
  logic             ld_out_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             start_take_s;

  // cnt never exceeds len_q, so this increment cannot wrap.
  assign cnt_inc_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign start_take_s = (state_r == S_IDLE) && start && !abort;

  // Next-state decode; abort overrides every normal transition.
  always_comb begin
    state_nx_s = state_r;
    if (abort) begin
      state_nx_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_nx_s = S_CLEAR;
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_CLEAR: begin
          if (len_q_r == {CNT_W{1'b0}}) begin
            state_nx_s = S_OUTPUT;
          end else begin
            state_nx_s = S_FETCH;
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            state_nx_s = S_ACC;
          end else begin
            state_nx_s = S_FETCH;
          end
        end
        S_ACC: begin
          if (cnt_inc_s == len_q_r) begin
            state_nx_s = S_OUTPUT;
          end else begin
            state_nx_s = S_FETCH;
          end
        end
        S_OUTPUT: state_nx_s = S_DONE;
        S_DONE: begin
          // A start arriving with out_ready is dropped: we only reach IDLE here.
          if (out_ready) begin
            state_nx_s = S_IDLE;
          end else begin
            state_nx_s = S_DONE;
          end
        end
        default: state_nx_s = S_IDLE;
      endcase
    end
  end

  // State, counters and registered Moore outputs (decoded from next state so
  // each strobe lines up exactly with the state it belongs to).
  always_ff @(negedge clk_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      len_q_r     <= {CNT_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b0;
      ld_acc_r    <= 1'b0;
      acc_clr_r   <= 1'b0;
      ld_out_r    <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (start_take_s) begin
        len_q_r <= len;
        cnt_r   <= {CNT_W{1'b0}};
      end else if (state_r == S_ACC) begin
        // ld_acc is already asserted in ACC, so the accumulator takes this
        // product even when abort arrives; cnt keeps step with it.
        cnt_r <= cnt_inc_s;
      end else begin
        cnt_r <= cnt_r;
      end
      in_ready_r  <= (state_nx_s == S_FETCH);
      ld_acc_r    <= (state_nx_s == S_CLEAR) || (state_nx_s == S_ACC);
      acc_clr_r   <= (state_nx_s == S_CLEAR);
      ld_out_r    <= (state_nx_s == S_OUTPUT);
      out_valid_r <= (state_nx_s == S_DONE);
      busy_r      <= (state_nx_s != S_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign ld_op     = in_valid & in_ready_r;
  assign ld_acc    = ld_acc_r;
  assign acc_clr   = acc_clr_r;
  assign ld_out    = ld_out_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign cnt       = cnt_r;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

  logic       clk_n;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic       ld_op;
  logic       ld_acc;
  logic       acc_clr;
  logic       ld_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic [7:0] cnt;

  int in_a;
  int in_b;

  mac_seq_ctrl #(.CNT_W(8)) dut (
    .clk_n(clk_n), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .ld_op(ld_op), .ld_acc(ld_acc),
    .acc_clr(acc_clr), .ld_out(ld_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .cnt(cnt)
  );

  initial clk_n = 1'b1;
  always #5 clk_n = ~clk_n;

  // Register datapath driven by the controller strobes, plus strobe counters.
  int a_q = 0, b_q = 0, acc_q = 0, res_q = 0;
  int n_ld_op = 0, n_ld_acc = 0, n_acc_clr = 0, n_ld_out = 0, n_in_ready = 0;
  always @(negedge clk_n) begin
    if (ld_op) begin
      a_q <= in_a;
      b_q <= in_b;
      n_ld_op <= n_ld_op + 1;
    end
    if (ld_acc) begin
      acc_q <= acc_clr ? 0 : acc_q + a_q * b_q;
      n_ld_acc <= n_ld_acc + 1;
    end
    if (ld_acc && acc_clr) n_acc_clr <= n_acc_clr + 1;
    if (ld_out) begin
      res_q <= acc_q;
      n_ld_out <= n_ld_out + 1;
    end
    if (in_ready) n_in_ready <= n_in_ready + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_n);
    @(posedge clk_n);
  endtask

  task automatic wait_ov(input string name, input int budget);
    for (int k = 0; k < budget && !out_valid; k++) cyc();
    chk(name, int'(out_valid), 1);
  endtask

  typedef struct {
    logic       rst_n, start;
    logic [7:0] len;
    logic       abort, in_valid, out_ready;
    int         a, b;
    logic       x_ld_op, x_busy, x_in_ready, x_ld_acc, x_acc_clr, x_ld_out, x_out_valid;
    logic [7:0] x_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [7:0] l,
                              input logic iv, input logic ordy, input int a, input int b,
                              input logic xop, input logic xb, input logic xir,
                              input logic xla, input logic xac, input logic xlo,
                              input logic xov, input logic [7:0] xc);
    vec_t v;
    v.rst_n = r; v.start = s; v.len = l; v.abort = 1'b0; v.in_valid = iv;
    v.out_ready = ordy; v.a = a; v.b = b;
    v.x_ld_op = xop; v.x_busy = xb; v.x_in_ready = xir; v.x_ld_acc = xla;
    v.x_acc_clr = xac; v.x_ld_out = xlo; v.x_out_valid = xov; v.x_cnt = xc;
    return v;
  endfunction

  vec_t vecs[11];
  int   s_op, s_acc, s_clr, s_out, s_ir;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rows: rst start len in_valid out_ready a b | ld_op(pre-edge) busy in_ready ld_acc acc_clr ld_out out_valid cnt
    vecs[0]  = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[1]  = mk(1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 2, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    vecs[2]  = mk(1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 2, 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[3]  = mk(1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 2, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[4]  = mk(1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 4, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    vecs[5]  = mk(1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 4, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    vecs[6]  = mk(1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    vecs[7]  = mk(1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    vecs[8]  = mk(1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    vecs[9]  = mk(1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    vecs[10] = mk(1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);

    rst_n = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_a = 0; in_b = 0;
    @(posedge clk_n);

    // Test 1 / reset: table-driven, len=3 with (2,3),(4,5),(1,7).
    s_op = n_ld_op; s_acc = n_ld_acc; s_clr = n_acc_clr; s_out = n_ld_out;
    for (int i = 0; i < 11; i++) begin
      rst_n = vecs[i].rst_n; start = vecs[i].start; len = vecs[i].len;
      abort = vecs[i].abort; in_valid = vecs[i].in_valid;
      out_ready = vecs[i].out_ready; in_a = vecs[i].a; in_b = vecs[i].b;
      #1;
      if (i > 0) chk($sformatf("v%0d ld_op", i), int'(ld_op), int'(vecs[i].x_ld_op));
      @(negedge clk_n);
      @(posedge clk_n);
      chk($sformatf("v%0d busy", i),      int'(busy),      int'(vecs[i].x_busy));
      chk($sformatf("v%0d in_ready", i),  int'(in_ready),  int'(vecs[i].x_in_ready));
      chk($sformatf("v%0d ld_acc", i),    int'(ld_acc),    int'(vecs[i].x_ld_acc));
      chk($sformatf("v%0d acc_clr", i),   int'(acc_clr),   int'(vecs[i].x_acc_clr));
      chk($sformatf("v%0d ld_out", i),    int'(ld_out),    int'(vecs[i].x_ld_out));
      chk($sformatf("v%0d out_valid", i), int'(out_valid), int'(vecs[i].x_out_valid));
      chk($sformatf("v%0d cnt", i),       int'(cnt),       int'(vecs[i].x_cnt));
    end
    chk("t1 result", res_q, 33);
    chk("t1 n_ld_op", n_ld_op - s_op, 3);
    chk("t1 n_ld_acc", n_ld_acc - s_acc, 4);
    chk("t1 n_acc_clr", n_acc_clr - s_clr, 1);
    chk("t1 n_ld_out", n_ld_out - s_out, 1);

    // Test 2: len=0 goes CLEAR, OUTPUT, DONE without touching the stream.
    out_ready = 1'b0; in_valid = 1'b1; in_a = 9; in_b = 9;
    s_op = n_ld_op; s_ir = n_in_ready;
    start = 1'b1; len = 8'd0;
    cyc();
    start = 1'b0;
    chk("t2 clear acc_clr", int'(acc_clr), 1);
    cyc();
    chk("t2 output ld_out", int'(ld_out), 1);
    chk("t2 output in_ready", int'(in_ready), 0);
    cyc();
    chk("t2 out_valid edge2", int'(out_valid), 1);
    chk("t2 result", res_q, 0);
    chk("t2 ld_op count", n_ld_op - s_op, 0);
    chk("t2 in_ready count", n_in_ready - s_ir, 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("t2 idle", int'(busy), 0);

    // Test 3: len=2 with 5-cycle stalls before each pair.
    in_valid = 1'b0; s_op = n_ld_op;
    start = 1'b1; len = 8'd2;
    cyc();
    start = 1'b0;
    cyc();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 5; k++) begin
        #1;
        chk($sformatf("t3 p%0d stall%0d ld_op", p, k), int'(ld_op), 0);
        cyc();
        chk($sformatf("t3 p%0d stall%0d in_ready", p, k), int'(in_ready), 1);
      end
      in_valid = 1'b1;
      in_a = (p == 0) ? 6 : 5;
      in_b = (p == 0) ? 7 : 8;
      #1;
      chk($sformatf("t3 p%0d ld_op", p), int'(ld_op), 1);
      cyc();
      in_valid = 1'b0;
      chk($sformatf("t3 p%0d acc", p), int'(ld_acc), 1);
      cyc();
    end
    chk("t3 output", int'(ld_out), 1);
    cyc();
    chk("t3 out_valid", int'(out_valid), 1);
    chk("t3 result", res_q, 82);
    chk("t3 ld_op count", n_ld_op - s_op, 2);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Test 4: DONE held with out_ready low; start pulses ignored.
    in_valid = 1'b1; in_a = 2; in_b = 2;
    start = 1'b1; len = 8'd1;
    cyc();
    start = 1'b0;
    wait_ov("t4 reach done", 20);
    for (int k = 0; k < 10; k++) begin
      start = (k == 3) ? 1'b1 : 1'b0;
      len = 8'd7;
      cyc();
      chk($sformatf("t4 hold%0d out_valid", k), int'(out_valid), 1);
    end
    chk("t4 result", res_q, 4);
    start = 1'b1; out_ready = 1'b1;
    cyc();
    chk("t4 release busy", int'(busy), 0);
    chk("t4 release out_valid", int'(out_valid), 0);
    start = 1'b0; out_ready = 1'b0;
    cyc();
    chk("t4 start ignored busy", int'(busy), 0);
    chk("t4 cnt kept", int'(cnt), 1);

    // Test 5: len=4, abort during the second ACC.
    in_valid = 1'b1; in_a = 1; in_b = 1; s_out = n_ld_out;
    start = 1'b1; len = 8'd4;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("t5 in acc2", int'(ld_acc), 1);
    chk("t5 acc2 cnt", int'(cnt), 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5 busy", int'(busy), 0);
    chk("t5 cnt", int'(cnt), 2);
    chk("t5 out_valid", int'(out_valid), 0);
    cyc();
    chk("t5 stays idle", int'(busy), 0);
    chk("t5 no ld_out", n_ld_out - s_out, 0);

    // Test 6: reset mid-FETCH, then a fresh len=1 run with (3,3).
    in_valid = 1'b0; s_out = n_ld_out;
    start = 1'b1; len = 8'd5;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    chk("t6 in fetch", int'(in_ready), 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("t6 busy", int'(busy), 0);
    chk("t6 in_ready", int'(in_ready), 0);
    chk("t6 ld_op", int'(ld_op), 0);
    chk("t6 ld_acc", int'(ld_acc), 0);
    chk("t6 acc_clr", int'(acc_clr), 0);
    chk("t6 ld_out", int'(ld_out), 0);
    chk("t6 out_valid", int'(out_valid), 0);
    chk("t6 cnt", int'(cnt), 0);
    chk("t6 no ld_out", n_ld_out - s_out, 0);
    @(posedge clk_n);
    in_valid = 1'b1; in_a = 3; in_b = 3;
    start = 1'b1; len = 8'd1;
    cyc();
    start = 1'b0;
    wait_ov("t6 reach done", 20);
    chk("t6 result", res_q, 9);
    chk("t6 final cnt", int'(cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
